// File: rtl/report_arbiter.sv
// Round-robin arbiter sharing one 24-bit report channel among N_SRC producers.
// Define REPORT_ARB_PRIO0_EN to make source 0 urgent (always wins when pending).
module report_arbiter #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC*24-1:0]  src_data,
  input  logic [N_SRC-1:0]     src_wr,
  output logic [ID_W+23:0]     tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [N_SRC-1:0]     overrun,
  input  logic                 clr_overrun
);

  localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_next;
  logic [23:0]        slot [N_SRC];
  logic [N_SRC-1:0]   pending, pending_next;
  logic [N_SRC-1:0]   overrun_next;
  logic [N_SRC-1:0]   cand;
  logic [N_SRC-1:0]   grant_onehot;
  logic [N_SRC-1:0]   ov_set;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic               load;
  logic               ptr_upd;
  int unsigned        idx;

  // Grant selection: first candidate scanning upward from ptr+1, wrapping.
  always_comb begin
    cand        = pending;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
`ifdef REPORT_ARB_PRIO0_EN
    cand[0] = 1'b0;
    if (pending[0]) begin
      grant_found = 1'b1;
    end
`endif
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!grant_found && cand[idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (grant_found) load = 1'b1;
          else             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    grant_onehot = load ? (N_SRC'(1) << grant_idx) : '0;
    // A strobe into the slot being granted re-arms it; the old word goes out.
    pending_next = (pending & ~grant_onehot) | src_wr;
    ov_set       = src_wr & pending & ~grant_onehot;
    overrun_next = (clr_overrun ? '0 : overrun) | ov_set;
`ifdef REPORT_ARB_PRIO0_EN
    ptr_upd = load && (grant_idx != '0);
`else
    ptr_upd = load;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      overrun <= '0;
      ptr     <= PTR_W'(N_SRC - 1);
      tx_data <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      overrun <= overrun_next;
      if (ptr_upd) ptr <= grant_idx;
      if (load)    tx_data <= {ID_W'(grant_idx), slot[grant_idx]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SRC; i++) slot[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (src_wr[i]) slot[i] <= src_data[24*i +: 24];
      end
    end
  end

  assign tx_valid = (state == SEND);

endmodule

// File: tb/tb_report_arbiter.sv
// Scoreboard bench for report_arbiter: directed stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted transfer.
module tb_report_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*24-1:0]   src_data = '0;
  logic [N-1:0]      src_wr = '0;
  logic [IW+23:0]    tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [N-1:0]      overrun;
  logic              clr_overrun = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] sb [$];

  report_arbiter #(.N_SRC(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_wr(src_wr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a transfer seen at negedge completes on the following posedge.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_valid && !prev_ready && tx_valid)
        check("hold_stable", tx_data, prev_data);
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) check("unexpected_word", tx_data, 32'hFFFF_FFFF);
        else                check("word", tx_data, sb.pop_front());
      end
    end
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_data  = tx_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_wr = '0;
    clr_overrun = 1'b0;
    tx_ready = 1'b0;
    sb.delete();
    step();
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", tx_data, 32'd0);
    check("rst_overrun", {28'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !tx_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic set_word(input int unsigned src, input logic [23:0] w);
    src_data[24*src +: 24] = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step();
    do_reset();

    // Single source, latency 2
    tx_ready = 1'b1;
    set_word(2, 24'h00002A);
    src_wr = 4'b0100;
    sb.push_back(32'h0200002A);
    step();
    src_wr = '0;
    check("lat_not_yet", {31'd0, tx_valid}, 32'd0);
    step();
    check("lat_valid", {31'd0, tx_valid}, 32'd1);
    check("lat_data", tx_data, 32'h0200002A);
    step();
    check("single_done", {31'd0, tx_valid}, 32'd0);
    drain("drain_single");
    check("single_overrun", {28'd0, overrun}, 32'd0);

    // Round-robin fairness, back-to-back
    do_reset();
    tx_ready = 1'b1;
    set_word(0, 24'h11); set_word(1, 24'h22); set_word(2, 24'h33); set_word(3, 24'h44);
    src_wr = 4'b1111;
    sb.push_back(32'h00000011); sb.push_back(32'h01000022);
    sb.push_back(32'h02000033); sb.push_back(32'h03000044);
    step();
    src_wr = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_b2b_valid", {31'd0, tx_valid}, 32'd1);
    end
    step();
    check("rr_end", {31'd0, tx_valid}, 32'd0);
    drain("drain_rr");

    // Backpressure
    do_reset();
    set_word(1, 24'h000123);
    src_wr = 4'b0010;
    sb.push_back(32'h01000123);
    step();
    src_wr = '0;
    step();
    for (int k = 0; k < 10; k++) begin
      check("bp_data", tx_data, 32'h01000123);
      check("bp_valid", {31'd0, tx_valid}, 32'd1);
      step();
    end
    tx_ready = 1'b1;
    step();
    check("bp_accept_once", {31'd0, tx_valid}, 32'd0);
    drain("drain_bp");

    // Overrun on unsent word, then clear
    do_reset();
    set_word(0, 24'h000100); set_word(1, 24'h000200);
    src_wr = 4'b0011;
    sb.push_back(32'h00000100);
    sb.push_back(32'h01ABCDEF);
    step();
    src_wr = '0;
    step();
    set_word(1, 24'hABCDEF);
    src_wr = 4'b0010;
    step();
    src_wr = '0;
    check("ovr_set", {28'd0, overrun}, 32'h2);
    tx_ready = 1'b1;
    drain("drain_ovr");
    check("ovr_sticky", {28'd0, overrun}, 32'h2);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("ovr_clr", {28'd0, overrun}, 32'd0);

    // Strobe in the grant cycle of the same source
    do_reset();
    tx_ready = 1'b1;
    set_word(0, 24'h000004);
    src_wr = 4'b0001;
    sb.push_back(32'h00000004);
    sb.push_back(32'h00000005);
    step();
    set_word(0, 24'h000005);
    step();
    src_wr = '0;
    drain("drain_sag");
    check("sag_overrun", {28'd0, overrun}, 32'd0);

    // Pointer continuity: last grant was 0, so 3 precedes 0 in round robin
    set_word(0, 24'h000777); set_word(3, 24'h000999);
    src_wr = 4'b1001;
`ifdef REPORT_ARB_PRIO0_EN
    sb.push_back(32'h00000777); sb.push_back(32'h03000999);
`else
    sb.push_back(32'h03000999); sb.push_back(32'h00000777);
`endif
    step();
    src_wr = '0;
    drain("drain_ptr");

    // Source 0 re-strobed while others pend
    do_reset();
    tx_ready = 1'b1;
    set_word(0, 24'h10); set_word(1, 24'h21); set_word(2, 24'h31); set_word(3, 24'h41);
    src_wr = 4'b1111;
`ifdef REPORT_ARB_PRIO0_EN
    sb.push_back(32'h00000010); sb.push_back(32'h01000021); sb.push_back(32'h00000011);
    sb.push_back(32'h02000031); sb.push_back(32'h00000012); sb.push_back(32'h03000041);
`else
    sb.push_back(32'h00000010); sb.push_back(32'h01000021); sb.push_back(32'h02000031);
    sb.push_back(32'h03000041); sb.push_back(32'h00000012);
`endif
    step();
    src_wr = '0;
    step();
    set_word(0, 24'h11);
    src_wr = 4'b0001;
    step();
    src_wr = '0;
    step();
    set_word(0, 24'h12);
    src_wr = 4'b0001;
    step();
    src_wr = '0;
    drain("drain_mix");
`ifdef REPORT_ARB_PRIO0_EN
    check("mix_overrun", {28'd0, overrun}, 32'd0);
`else
    check("mix_overrun", {28'd0, overrun}, 32'h1);
`endif

    // Asynchronous reset while a word is held
    do_reset();
    set_word(2, 24'h0000EE);
    src_wr = 4'b0100;
    step();
    src_wr = '0;
    step();
    check("mid_valid", {31'd0, tx_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_valid", {31'd0, tx_valid}, 32'd0);
    check("async_data", tx_data, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_idle", {31'd0, tx_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
